// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory handshake signals around the arbiter.
// The arbiter takes the slave view; the requesters and memory together take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_flush;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [BE_WIDTH-1:0]   d_be;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  m_req;
  logic                  m_we;
  logic [BE_WIDTH-1:0]   m_be;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_gnt;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;

  logic                  busy;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata,
    output busy
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port, one transaction in flight.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t                state_reg, state_next;
  owner_t                owner_reg, owner_next;
  logic                  we_reg, we_next;
  logic [BE_WIDTH-1:0]   be_reg, be_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [3:0]            starve_reg, starve_next;
  logic                  discard_reg, discard_next;

  logic fetch_wins;
  logic m_req_c, i_gnt_c, d_gnt_c, i_rvalid_c, d_rvalid_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_FETCH;
      we_reg      <= 1'b0;
      be_reg      <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      starve_reg  <= 4'd0;
      discard_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      we_reg      <= we_next;
      be_reg      <= be_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      starve_reg  <= starve_next;
      discard_reg <= discard_next;
    end
  end

  assign fetch_wins = bus.i_req && (!bus.d_req || (starve_reg == STARVE_MAX));

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    we_next      = we_reg;
    be_next      = be_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    starve_next  = starve_reg;
    discard_next = discard_reg;
    m_req_c      = 1'b0;
    i_gnt_c      = 1'b0;
    d_gnt_c      = 1'b0;
    i_rvalid_c   = 1'b0;
    d_rvalid_c   = 1'b0;

    case (state_reg)
      IDLE: begin
        discard_next = 1'b0;
        if (bus.i_req || bus.d_req) begin
          state_next = REQ;
          if (fetch_wins) begin
            owner_next  = OWN_FETCH;
            we_next     = 1'b0;
            be_next     = '1;
            addr_next   = bus.i_addr;
            wdata_next  = '0;
            starve_next = 4'd0;
          end else begin
            owner_next = OWN_DATA;
            we_next    = bus.d_we;
            be_next    = bus.d_be;
            addr_next  = bus.d_addr;
            wdata_next = bus.d_wdata;
            // Only a contested loss counts towards fetch starvation.
            if (bus.i_req) starve_next = starve_reg + 4'd1;
          end
        end
      end
      REQ: begin
        m_req_c = 1'b1;
        if (bus.i_flush && owner_reg == OWN_FETCH) discard_next = 1'b1;
        if (bus.m_gnt) begin
          state_next = RESP;
          i_gnt_c    = (owner_reg == OWN_FETCH);
          d_gnt_c    = (owner_reg == OWN_DATA);
        end
      end
      RESP: begin
        if (bus.i_flush && owner_reg == OWN_FETCH) discard_next = 1'b1;
        if (bus.m_rvalid) begin
          // A flush arriving in the very response cycle still kills the fetch data.
          i_rvalid_c   = (owner_reg == OWN_FETCH) && !discard_reg && !bus.i_flush;
          d_rvalid_c   = (owner_reg == OWN_DATA);
          state_next   = IDLE;
          discard_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.m_req    = m_req_c;
  assign bus.m_we     = we_reg;
  assign bus.m_be     = be_reg;
  assign bus.m_addr   = addr_reg;
  assign bus.m_wdata  = wdata_reg;
  assign bus.i_gnt    = i_gnt_c;
  assign bus.d_gnt    = d_gnt_c;
  assign bus.i_rvalid = i_rvalid_c;
  assign bus.d_rvalid = d_rvalid_c;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign bus.busy     = (state_reg != IDLE);
endmodule
